// File: rtl/ita_divider_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : ita_divider_bank_if
// Brief    : Softmax division channel. The softmax unit is the master: it
//            drives the shared denominator bus, per-lane request valids and
//            per-lane result readies. The divider bank is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface ita_divider_bank_if #(
    parameter int NUM_DIV   = 4,
    parameter int IN_WIDTH  = 19,
    parameter int OUT_WIDTH = 24
);
    // Request side: one shared denominator, one valid/ready pair per lane
    logic [IN_WIDTH-1:0]                div_inp_i;
    logic [NUM_DIV-1:0]                 div_valid_i;
    logic [NUM_DIV-1:0]                 div_ready_o;

    // Response side: one quotient with valid/ready per lane
    logic [NUM_DIV-1:0]                 div_valid_o;
    logic [NUM_DIV-1:0]                 div_ready_i;
    logic [NUM_DIV-1:0][OUT_WIDTH-1:0]  div_oup_o;

    modport master (
        output div_inp_i,
        output div_valid_i,
        input  div_ready_o,
        input  div_valid_o,
        output div_ready_i,
        input  div_oup_o
    );

    modport slave (
        input  div_inp_i,
        input  div_valid_i,
        output div_ready_o,
        output div_valid_o,
        input  div_ready_i,
        output div_oup_o
    );
endinterface
`default_nettype wire

// File: rtl/ita_divider_bank.sv
`default_nettype none
// ============================================================================
// Module   : ita_divider_bank
// Brief    : Bank of NUM_DIV independent restoring serial dividers computing
//            floor(2^NUM_SHIFT / den) for the softmax normalisation step.
//            Each lane: IDLE -> BUSY (NUM_SHIFT+1 cycles) -> DONE -> IDLE.
//            den == 0 skips BUSY and returns an all-ones quotient.
//            Optional performance counters are enabled with the macro
//            ITA_DIV_PERF_EN; without it the perf ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ita_divider_bank #(
    parameter int NUM_DIV   = 4,
    parameter int IN_WIDTH  = 19,
    parameter int OUT_WIDTH = 24,
    parameter int NUM_SHIFT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    ita_divider_bank_if.slave   div_if,
    output logic [31:0]         perf_div_count_o,
    output logic [31:0]         perf_stall_o
);

    // Counter walks numerator bit positions NUM_SHIFT down to 0
    localparam int                       c_cnt_width = $clog2(NUM_SHIFT + 1);
    localparam logic [c_cnt_width-1:0]   c_cnt_start = c_cnt_width'(NUM_SHIFT);

    // Lane state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [NUM_DIV-1:0]                 w_ready_vec;
    logic [NUM_DIV-1:0]                 w_valid_vec;
    logic [NUM_DIV-1:0][OUT_WIDTH-1:0]  w_oup_vec;

    assign div_if.div_ready_o = w_ready_vec;
    assign div_if.div_valid_o = w_valid_vec;
    assign div_if.div_oup_o   = w_oup_vec;

    for (genvar l = 0; l < NUM_DIV; l++) begin : g_lane
        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic [IN_WIDTH-1:0]    r_den;
        // Remainder always stays below den, so the top bit is a guard only
        logic [IN_WIDTH:0]      r_rem;
        // Quotient bits shifted in so far; the final bit is appended on exit
        logic [NUM_SHIFT-1:0]   r_quot;
        logic [OUT_WIDTH-1:0]   r_oup;
        logic [c_cnt_width-1:0] r_cnt;

        logic                   w_accept;
        logic                   w_respond;
        logic                   w_num_bit;
        logic                   w_last;
        logic                   w_ge;
        logic [IN_WIDTH+1:0]    w_shift;
        logic [IN_WIDTH:0]      w_diff;
        logic                   w_ready;
        logic                   w_valid;

        assign w_accept  = div_if.div_valid_i[l] && (r_state == c_st_idle);
        assign w_respond = div_if.div_ready_i[l] && (r_state == c_st_done);

        // Numerator is a single one at bit NUM_SHIFT, zeros below
        assign w_num_bit = (r_cnt == c_cnt_start);
        assign w_last    = (r_cnt == '0);
        assign w_shift   = {r_rem, w_num_bit};
        assign w_ge      = (w_shift >= {2'b00, r_den});
        // Only consumed when w_ge, where the true difference fits IN_WIDTH+1 bits
        assign w_diff    = w_shift[IN_WIDTH:0] - {1'b0, r_den};

        // State register; reset and clear abort any lane activity
        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                r_state <= c_st_idle;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Next-state logic
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        w_state_nxt = (div_if.div_inp_i == '0) ? c_st_done : c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (w_last) begin
                        w_state_nxt = c_st_done;
                    end
                end
                c_st_done: begin
                    if (w_respond) begin
                        w_state_nxt = c_st_idle;
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end

        // Handshake outputs decoded from state
        always_comb begin
            w_ready = 1'b0;
            w_valid = 1'b0;
            case (r_state)
                c_st_idle: w_ready = 1'b1;
                c_st_done: w_valid = 1'b1;
                default: ;
            endcase
        end

        // Datapath: capture on accept, one restoring step per BUSY cycle
        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                r_den  <= '0;
                r_rem  <= '0;
                r_quot <= '0;
                r_cnt  <= '0;
                r_oup  <= '0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_accept) begin
                            r_den  <= div_if.div_inp_i;
                            r_rem  <= '0;
                            r_quot <= '0;
                            r_cnt  <= c_cnt_start;
                            if (div_if.div_inp_i == '0) begin
                                r_oup <= '1;
                            end
                        end
                    end
                    c_st_busy: begin
                        r_rem  <= w_ge ? w_diff : w_shift[IN_WIDTH:0];
                        r_quot <= {r_quot[NUM_SHIFT-2:0], w_ge};
                        r_cnt  <= r_cnt - 1'b1;
                        if (w_last) begin
                            r_oup <= OUT_WIDTH'({r_quot, w_ge});
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign w_ready_vec[l] = w_ready;
        assign w_valid_vec[l] = w_valid;
        assign w_oup_vec[l]   = r_oup;
    end

`ifdef ITA_DIV_PERF_EN
    logic [31:0] r_perf_cnt;
    logic [31:0] r_perf_stall;
    logic [31:0] w_done_inc;
    logic [31:0] w_stall_inc;

    // Count completed and stalled lanes this cycle
    always_comb begin
        w_done_inc  = '0;
        w_stall_inc = '0;
        for (int i = 0; i < NUM_DIV; i++) begin
            w_done_inc  = w_done_inc  + 32'(w_valid_vec[i] &  div_if.div_ready_i[i]);
            w_stall_inc = w_stall_inc + 32'(w_valid_vec[i] & ~div_if.div_ready_i[i]);
        end
    end

    // Free-running counters; a clear cycle discards handshakes so it adds nothing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_cnt   <= '0;
            r_perf_stall <= '0;
        end else if (!clear_i) begin
            r_perf_cnt   <= r_perf_cnt   + w_done_inc;
            r_perf_stall <= r_perf_stall + w_stall_inc;
        end
    end

    assign perf_div_count_o = r_perf_cnt;
    assign perf_stall_o     = r_perf_stall;
`else
    assign perf_div_count_o = '0;
    assign perf_stall_o     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ita_divider_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ita_divider_bank
// Brief    : Randomized and directed bench for ita_divider_bank against a
//            timestamp-based lane model (quotient by plain integer division).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ita_divider_bank;

    localparam int ND   = 4;
    localparam int IW   = 19;
    localparam int OW   = 24;
    localparam int NS   = 16;
    localparam int LAT  = NS + 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic [31:0] perf_div_count_o;
    logic [31:0] perf_stall_o;

    ita_divider_bank_if #(.NUM_DIV(ND), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dif ();

    ita_divider_bank #(
        .NUM_DIV   (ND),
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .NUM_SHIFT (NS)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clear_i          (clear_i),
        .div_if           (dif),
        .perf_div_count_o (perf_div_count_o),
        .perf_stall_o     (perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Lane model: pending request, cycle at which its result becomes visible
    int          cyc = 0;
    bit          m_pend [ND];
    int          m_due  [ND];
    logic [OW-1:0] m_q  [ND];
    logic [31:0] m_cnt   = 0;
    logic [31:0] m_stall = 0;

    function automatic logic [OW-1:0] ref_quot(input int unsigned den);
        if (den == 0) return {OW{1'b1}};
        return OW'((64'd1 << NS) / den);
    endfunction

    function automatic bit exp_valid(input int l);
        return m_pend[l] && (cyc >= m_due[l]);
    endfunction

    function automatic logic [31:0] exp_perf_cnt();
`ifdef ITA_DIV_PERF_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_perf_stall();
`ifdef ITA_DIV_PERF_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    // Advance the model over the coming edge using current inputs, then clock
    task automatic tick();
        bit vis;
        for (int l = 0; l < ND; l++) begin
            vis = exp_valid(l);
            if (!rst_i && !clear_i) begin
                if (vis && dif.div_ready_i[l])  m_cnt++;
                if (vis && !dif.div_ready_i[l]) m_stall++;
            end
            if (rst_i || clear_i) begin
                m_pend[l] = 1'b0;
            end else if (vis && dif.div_ready_i[l]) begin
                m_pend[l] = 1'b0;
            end else if (!m_pend[l] && dif.div_valid_i[l]) begin
                m_pend[l] = 1'b1;
                m_due[l]  = cyc + ((dif.div_inp_i == 0) ? 1 : LAT);
                m_q[l]    = ref_quot(dif.div_inp_i);
            end
        end
        if (rst_i) begin
            m_cnt   = 0;
            m_stall = 0;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_i = 1'b0;
        dif.div_inp_i   = '0;
        dif.div_valid_i = '0;
        dif.div_ready_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        n_checks++;
        if (dif.div_ready_o !== 4'hF) begin
            n_fail++; $display("FAIL reset_ready: got %h expected F", dif.div_ready_o);
        end
        n_checks++;
        if (dif.div_valid_o !== 4'h0) begin
            n_fail++; $display("FAIL reset_valid: got %h expected 0", dif.div_valid_o);
        end
        n_checks++;
        if (dif.div_oup_o !== '0) begin
            n_fail++; $display("FAIL reset_oup: got %h expected 0", dif.div_oup_o);
        end
        n_checks++;
        if (perf_div_count_o !== 32'd0 || perf_stall_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_div_count_o, perf_stall_o);
        end
    endtask

    task automatic test_single_lane();
        dif.div_ready_i = 4'hF;
        dif.div_inp_i   = 19'd256;
        dif.div_valid_i = 4'b0001;
        tick();
        dif.div_valid_i = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if (dif.div_valid_o[0] !== (k == LAT - 1)) begin
                n_fail++; $display("FAIL single_valid k=%0d: got %b expected %b", k, dif.div_valid_o[0], (k == LAT - 1));
            end
            n_checks++;
            if (dif.div_ready_o[0] !== (k >= LAT)) begin
                n_fail++; $display("FAIL single_ready k=%0d: got %b expected %b", k, dif.div_ready_o[0], (k >= LAT));
            end
            if (k == LAT - 1) begin
                n_checks++;
                if (dif.div_oup_o[0] !== 24'd256) begin
                    n_fail++; $display("FAIL single_oup: got %0d expected 256", dif.div_oup_o[0]);
                end
            end
        end
    endtask

    task automatic test_all_lanes();
        logic [IW-1:0] dens [ND];
        dens[0] = 19'd1; dens[1] = 19'd3; dens[2] = 19'd65536; dens[3] = 19'h7FFFF;
        dif.div_ready_i = 4'h0;
        for (int i = 0; i < ND; i++) begin
            dif.div_inp_i   = dens[i];
            dif.div_valid_i = 4'(1 << i);
            tick();
        end
        dif.div_valid_i = 4'h0;
        for (int k = 0; k < 22; k++) begin
            tick();
            for (int l = 0; l < ND; l++) begin
                n_checks++;
                if (dif.div_valid_o[l] !== exp_valid(l)) begin
                    n_fail++; $display("FAIL lanes_valid lane%0d cyc%0d: got %b expected %b", l, cyc, dif.div_valid_o[l], exp_valid(l));
                end
                if (exp_valid(l)) begin
                    n_checks++;
                    if (dif.div_oup_o[l] !== m_q[l]) begin
                        n_fail++; $display("FAIL lanes_oup lane%0d: got %0d expected %0d", l, dif.div_oup_o[l], m_q[l]);
                    end
                end
            end
        end
        n_checks++;
        if (m_q[0] !== 24'd65536 || m_q[1] !== 24'd21845 || m_q[2] !== 24'd1 || m_q[3] !== 24'd0
            || dif.div_oup_o[0] !== 24'd65536 || dif.div_oup_o[3] !== 24'd0) begin
            n_fail++; $display("FAIL lanes_known: got %0d,%0d,%0d,%0d expected 65536,21845,1,0",
                               dif.div_oup_o[0], dif.div_oup_o[1], dif.div_oup_o[2], dif.div_oup_o[3]);
        end
        dif.div_ready_i = 4'hF;
        repeat (2) tick();
        n_checks++;
        if (dif.div_ready_o !== 4'hF) begin
            n_fail++; $display("FAIL lanes_drain: got %h expected F", dif.div_ready_o);
        end
    endtask

    task automatic test_zero_den();
        dif.div_ready_i = 4'h0;
        dif.div_inp_i   = '0;
        dif.div_valid_i = 4'b0100;
        tick();
        dif.div_valid_i = 4'h0;
        n_checks++;
        if (dif.div_valid_o[2] !== 1'b1) begin
            n_fail++; $display("FAIL zero_valid: got %b expected 1", dif.div_valid_o[2]);
        end
        n_checks++;
        if (dif.div_oup_o[2] !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL zero_oup: got %h expected FFFFFF", dif.div_oup_o[2]);
        end
        dif.div_ready_i = 4'hF;
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] base_cnt;
        logic [31:0] base_stall;
        dif.div_ready_i = 4'hF;
        dif.div_ready_i[1] = 1'b0;
        dif.div_inp_i   = 19'd5;
        dif.div_valid_i = 4'b0010;
        tick();
        dif.div_valid_i = 4'h0;
        repeat (LAT - 1) tick();
        base_cnt   = exp_perf_cnt();
        base_stall = exp_perf_stall();
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (dif.div_valid_o[1] !== 1'b1 || dif.div_oup_o[1] !== 24'd13107) begin
                n_fail++; $display("FAIL stall_hold k=%0d: got v=%b q=%0d expected v=1 q=13107", k, dif.div_valid_o[1], dif.div_oup_o[1]);
            end
            dif.div_inp_i      = 19'd7;
            dif.div_valid_i[1] = k[0];
            tick();
        end
        dif.div_valid_i = 4'h0;
        dif.div_ready_i[1] = 1'b1;
        tick();
        n_checks++;
        if (dif.div_valid_o[1] !== 1'b0 || dif.div_ready_o[1] !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got v=%b r=%b expected v=0 r=1", dif.div_valid_o[1], dif.div_ready_o[1]);
        end
`ifdef ITA_DIV_PERF_EN
        n_checks++;
        if (perf_stall_o !== base_stall + 32'd10 || perf_div_count_o !== base_cnt + 32'd1) begin
            n_fail++; $display("FAIL stall_perf: got %0d/%0d expected %0d/%0d", perf_stall_o, perf_div_count_o, base_stall + 10, base_cnt + 1);
        end
`else
        n_checks++;
        if (perf_stall_o !== 32'd0 || perf_div_count_o !== 32'd0 || base_cnt !== 32'd0) begin
            n_fail++; $display("FAIL stall_perf: got %0d/%0d expected 0/0", perf_stall_o, perf_div_count_o);
        end
`endif
    endtask

    task automatic test_reset_mid_busy();
        dif.div_ready_i = 4'hF;
        dif.div_inp_i   = 19'd1234;
        dif.div_valid_i = 4'b1000;
        tick();
        dif.div_valid_i = 4'h0;
        repeat (8) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_checks++;
        if (dif.div_ready_o !== 4'hF || dif.div_valid_o !== 4'h0) begin
            n_fail++; $display("FAIL rst_mid: got r=%h v=%h expected r=F v=0", dif.div_ready_o, dif.div_valid_o);
        end
        n_checks++;
        if (perf_div_count_o !== 32'd0 || perf_stall_o !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_perf: got %0d/%0d expected 0/0", perf_div_count_o, perf_stall_o);
        end
        dif.div_inp_i   = 19'd2;
        dif.div_valid_i = 4'b1000;
        tick();
        dif.div_valid_i = 4'h0;
        for (int k = 1; k < LAT; k++) begin
            tick();
            n_checks++;
            if (dif.div_valid_o[3] !== (k == LAT - 1)) begin
                n_fail++; $display("FAIL rst_new_valid k=%0d: got %b expected %b", k, dif.div_valid_o[3], (k == LAT - 1));
            end
        end
        n_checks++;
        if (dif.div_oup_o[3] !== 24'd32768) begin
            n_fail++; $display("FAIL rst_new_oup: got %0d expected 32768", dif.div_oup_o[3]);
        end
        tick();
    endtask

    task automatic test_clear_handshake();
        logic [31:0] base_cnt;
        dif.div_ready_i = 4'h0;
        dif.div_inp_i   = 19'd100;
        dif.div_valid_i = 4'b0001;
        tick();
        dif.div_valid_i = 4'h0;
        repeat (LAT - 1) tick();
        n_checks++;
        if (dif.div_valid_o[0] !== 1'b1 || dif.div_oup_o[0] !== 24'd655) begin
            n_fail++; $display("FAIL clear_pre: got v=%b q=%0d expected v=1 q=655", dif.div_valid_o[0], dif.div_oup_o[0]);
        end
        base_cnt = exp_perf_cnt();
        dif.div_ready_i = 4'h1;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_checks++;
        if (dif.div_ready_o[0] !== 1'b1 || dif.div_valid_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL clear_idle: got r=%b v=%b expected r=1 v=0", dif.div_ready_o[0], dif.div_valid_o[0]);
        end
        n_checks++;
        if (perf_div_count_o !== base_cnt || perf_stall_o !== exp_perf_stall()) begin
            n_fail++; $display("FAIL clear_perf: got %0d/%0d expected %0d/%0d", perf_div_count_o, perf_stall_o, base_cnt, exp_perf_stall());
        end
    endtask

    task automatic test_random();
        int unsigned sel;
        for (int c = 0; c < 700; c++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      dif.div_inp_i = '0;
            else if (sel == 1) dif.div_inp_i = IW'($urandom_range(1, 300));
            else               dif.div_inp_i = IW'($urandom_range(0, (1 << IW) - 1));
            dif.div_valid_i = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            dif.div_ready_i = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            clear_i = ($urandom_range(0, 99) == 0);
            tick();
            for (int l = 0; l < ND; l++) begin
                n_checks++;
                if (dif.div_valid_o[l] !== exp_valid(l)) begin
                    n_fail++; $display("FAIL rand_valid lane%0d cyc%0d: got %b expected %b", l, cyc, dif.div_valid_o[l], exp_valid(l));
                end
                n_checks++;
                if (dif.div_ready_o[l] !== !m_pend[l]) begin
                    n_fail++; $display("FAIL rand_ready lane%0d cyc%0d: got %b expected %b", l, cyc, dif.div_ready_o[l], !m_pend[l]);
                end
                if (exp_valid(l)) begin
                    n_checks++;
                    if (dif.div_oup_o[l] !== m_q[l]) begin
                        n_fail++; $display("FAIL rand_oup lane%0d cyc%0d: got %0d expected %0d", l, cyc, dif.div_oup_o[l], m_q[l]);
                    end
                end
            end
            n_checks++;
            if (perf_div_count_o !== exp_perf_cnt() || perf_stall_o !== exp_perf_stall()) begin
                n_fail++; $display("FAIL rand_perf cyc%0d: got %0d/%0d expected %0d/%0d", cyc, perf_div_count_o, perf_stall_o, exp_perf_cnt(), exp_perf_stall());
            end
        end
        clear_i = 1'b0;
        dif.div_valid_i = 4'h0;
        dif.div_ready_i = 4'hF;
        repeat (LAT + 2) tick();
        n_checks++;
        if (dif.div_ready_o !== 4'hF || dif.div_valid_o !== 4'h0) begin
            n_fail++; $display("FAIL rand_drain: got r=%h v=%h expected r=F v=0", dif.div_ready_o, dif.div_valid_o);
        end
    endtask

    initial begin
        for (int l = 0; l < ND; l++) begin
            m_pend[l] = 1'b0;
            m_due[l]  = 0;
            m_q[l]    = '0;
        end
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_zero_den();
        test_stall();
        test_reset_mid_busy();
        test_clear_handshake();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ita_divider_bank.md
Name: ita_divider_bank

Overview:
- Responder end of the softmax division interface: a bank of NumDiv independent serial dividers.
- Each lane accepts one exp-sum denominator from the softmax unit's division FIFO and computes the normalisation reciprocal floor(2^NumShift / den).
- Each lane returns its result on a per-lane valid/ready channel, which the softmax unit writes back to its accumulator buffer.
- The softmax unit rotates requests and responses round-robin across lanes; this block imposes no ordering between lanes.

Parameters:
- NumDiv, 4, number of divider lanes.
- InWidth, 19, denominator width (matches the softmax accumulator data width).
- OutWidth, 24, quotient width per lane.
- NumShift, 16, numerator exponent; numerator = 2^NumShift. Constraint: NumShift+1 <= OutWidth.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous abort; all lanes return to IDLE.
- div_inp_i  in  InWidth  shared denominator bus, unsigned.
- div_valid_i  in  NumDiv  per-lane request valid.
- div_ready_o  out  NumDiv  per-lane request ready.
- div_valid_o  out  NumDiv  per-lane result valid.
- div_ready_i  in  NumDiv  per-lane result ready.
- div_oup_o  out  NumDiv x OutWidth  per-lane quotient.
- perf_div_count_o  out  32  completed responses (optional feature).
- perf_stall_o  out  32  result-stall cycles (optional feature).

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset and clear_i: all lanes go to IDLE; div_ready_o = all ones; div_valid_o = 0; div_oup_o = 0; perf counters = 0. clear_i does not clear the perf counters. rst_i and clear_i override every other event in the same cycle, including a result handshake, which is discarded.
- Per-lane FSM states: IDLE, BUSY, DONE.
- IDLE:
  - div_ready_o[i] = 1.
  - On div_valid_i[i] && div_ready_o[i], capture div_inp_i into den_q.
  - If div_inp_i == 0: go to DONE with quotient = all ones (OutWidth bits).
  - Otherwise: remainder = 0, quotient = 0, bit counter = NumShift; go to BUSY.
- BUSY:
  - div_ready_o[i] = 0.
  - Restoring division, one quotient bit per cycle, MSB first, over numerator bits NumShift down to 0.
  - Per cycle: rem' = {rem, num_bit}. If rem' >= den: rem = rem' - den and the quotient bit is 1; otherwise rem = rem' and the quotient bit is 0.
  - Remainder width is InWidth+1; no overflow is possible.
  - After bit 0 (NumShift+1 cycles in BUSY), go to DONE.
- DONE:
  - div_valid_o[i] = 1; div_oup_o[i] holds the quotient, zero-extended to OutWidth.
  - Holds stable until div_ready_i[i]; on handshake go to IDLE.
  - div_ready_o[i] stays 0 during DONE. No same-cycle accept-and-respond bypass.
- Latency: request accepted in cycle t → div_valid_o in cycle t+NumShift+2 (18 at default). den=0 → valid in cycle t+1.
- Throughput: per lane, one result every NumShift+3 cycles, assuming div_ready_i is held high.
- div_oup_o[i] is valid only while div_valid_o[i] = 1. It holds its last value otherwise; the bench must not check it outside valid.
- div_valid_i[i] asserted while the lane is BUSY or DONE: ignored, no capture. The requester must hold the request until ready.
- Multiple div_valid_i bits in one cycle: every lane that is ready captures the same div_inp_i. This is legal but the softmax unit never does it.
- Lanes are fully independent; simultaneous handshakes on different lanes are all honoured.
- Quotient upper bound: den=1 gives 2^NumShift, which fits in NumShift+1 bits, so no saturation is needed except for den=0.

Optional Feature:
- Macro ITA_DIV_PERF_EN.
- Defined:
  - perf_div_count_o increments by popcount(div_valid_o & div_ready_i) each cycle.
  - perf_stall_o increments by popcount(div_valid_o & ~div_ready_i) each cycle.
  - Both wrap at 2^32 and are cleared only by rst_i.
- Not defined: both ports are tied to 0 and no counter registers are instantiated.

Test Plan:
- Lane 0: den=256, div_ready_i=1 → div_oup_o[0]=256 with div_valid_o[0] high exactly 18 cycles after acceptance, for one cycle; div_ready_o[0] back to 1 in the following cycle.
- Lanes 0..3 accept den=1, 3, 65536, 0x7FFFF in consecutive cycles → results 65536, 21845, 1, 0. Each arrives 18 cycles after its own accept; no cross-lane corruption.
- den=0 on lane 2 → div_valid_o[2] one cycle after accept, div_oup_o[2]=0xFFFFFF.
- Lane 1 den=5, div_ready_i[1] held low 10 cycles after result valid → div_oup_o[1]=13107 stable and valid high throughout; div_valid_i[1] pulses meanwhile are ignored. With ITA_DIV_PERF_EN, perf_stall_o=10 and perf_div_count_o=1 after release.
- rst_i asserted mid-BUSY on lane 3 (cycle 8 of 17) → next cycle div_ready_o=4'hF, div_valid_o=0. New request den=2 completes with 32768 at full latency.
- clear_i in the same cycle as a lane-0 result handshake → lane 0 is IDLE next cycle; perf_div_count_o does not increment.
